k051962_tile_serializer: RTL and testbench
==========================================

Name: k051962_tile_serializer

Overview:
- Downstream pixel stage for one tile layer. Consumes the per-tile GFX ROM row (32 bits, 4 planes × 8 pixels) and the COL attribute byte produced by the tile layer generator.
- Serializes that data into a 4-bit pixel index plus 8-bit colour attribute, one pixel per pixel-enable.
- Applies the ZA/ZB fine horizontal scroll (0–7 pixels) and per-tile X-flip.
- Feeds the priority/mixer stage.

Parameters:
- PIX_BITS, 4, bits per pixel (number of planes).
- TILE_W, 8, pixels per tile row; phase counter is clog2(TILE_W) bits.
- COL_W, 8, colour attribute width.

Ports:
- M24  input  1  master clock; all state on rising edge.
- RES  input  1  asynchronous active-low reset.
- PIXCE  input  1  one-M24-cycle pixel enable strobe (1 per pixel, M24/4 nominal).
- LINE_CLR  input  1  synchronous line start; forces phase counter to 0 on next PIXCE-qualified edge.
- ZH  input  3  fine scroll value ({Z4H,Z2H,Z1H}).
- ROM_STB  input  1  one-cycle strobe: ROM_D/COL_IN/FLIPX valid.
- ROM_D  input  32  planar row; byte k = plane k; bit 7 of each byte = leftmost pixel.
- COL_IN  input  COL_W  attribute for this tile.
- FLIPX  input  1  horizontal flip for this tile.
- PIX  output  PIX_BITS  current pixel index (0 = transparent).
- PCOL  output  COL_W  attribute of current pixel's tile.
- LOAD  output  1  one-cycle pulse: tile boundary taken this PIXCE.
- UNDR  output  1  one-cycle pulse: boundary reached with holding register empty.
- OVR  output  1  one-cycle pulse: ROM_STB overwrote unconsumed holding data.

Behaviour:
- Reset (RES=0, async):
  - PIX=0, PCOL=0, LOAD=UNDR=OVR=0.
  - Phase counter ph=0, holding empty (HFULL=0), shift registers 0, current flip=0.
- Phase counter:
  - On PIXCE, ph <= ph+1 mod 8.
  - If LINE_CLR and PIXCE in the same cycle, ph <= 0 (LINE_CLR wins).
  - LINE_CLR without PIXCE is held pending until the next PIXCE, then ph <= 0.
- Holding register:
  - On ROM_STB, latch ROM_D, COL_IN, FLIPX and set HFULL=1.
  - If HFULL=1 and no load occurs this cycle, OVR pulses (newer data kept).
- Load event: PIXCE && ph==ZH (ZH sampled on the same edge).
  - LOAD pulses.
  - If HFULL: shifter <= holding; PCOL <= holding COL; flip <= holding FLIPX; HFULL <= 0.
  - If not HFULL: shifter <= 0, PCOL <= 0, UNDR pulses.
  - If ROM_STB coincides with the load: the load takes the old holding contents, the new data enters holding, HFULL stays 1, no OVR. If HFULL was 0, the load takes the ROM_D bypass (no UNDR) and HFULL ends 0.
- Pixel output, updated only on PIXCE (registered):
  - Pixel i of a row = {ROM_D[24+b], ROM_D[16+b], ROM_D[8+b], ROM_D[b]} with b = 7−i (no flip) or b = i (flip).
  - On the load PIXCE, PIX takes pixel 0 of the newly loaded row. Latency: data visible on PIX 1 M24 cycle after the load edge.
  - On each non-load PIXCE, the shifter advances one pixel and PIX takes the next pixel.
  - After 8 pixels without a load, zeros shift in (PIX=0) and PCOL holds.
- ZH change mid-tile: the new value takes effect at the next compare; the tile is shortened or lengthened accordingly. No error is flagged.
- Between PIXCE strobes, all outputs hold.

Decomposition:
- Package k051962_pkg holds:
  - constants TILE_W, PIX_BITS, COL_W;
  - plane-select function mapping (row, pixel index, flip) to a PIX_BITS vector;
  - typedef for the holding-register struct {data, col, flip}.
- One sub-module, k051962_plane_shift: a single-plane 8-bit load/shift register with a direction input. It is instantiated PIX_BITS times; the top level holds phase, holding, load and flag logic.

Test Plan:
- Reset mid-line: RES=0 while PIX=4'hA → PIX=0, PCOL=0, HFULL=0 immediately (async); after release, first load with no ROM_STB → UNDR=1, PIX=0.
- ZH=0, ROM_STB with ROM_D=32'hFF00_FF00 (planes 1 and 3 all ones), COL_IN=8'h5C, FLIPX=0 → at ph=0 LOAD=1, then 8 PIXCE give PIX=4'hA, PCOL=8'h5C.
- ROM_D=32'h0000_0080, ZH=0 → PIX sequence 1,0,0,0,0,0,0,0; same data with FLIPX=1 → 0,0,0,0,0,0,0,1.
- ZH=3 with LINE_CLR at line start → first LOAD on the 4th PIXCE after LINE_CLR (ph==3); row boundaries every 8 PIXCE thereafter.
- Two ROM_STB (rows A then B) before any load → OVR=1 on the second strobe; next load outputs row B pixels.
- ROM_STB in the same cycle as the load with HFULL=1 → shifter gets the old row, HFULL stays 1, OVR=0, UNDR=0; the next load outputs the new row.

Source files
------------

// File: rtl/k051962_pkg.sv
// Shared constants, holding-register type and plane-select helper for the
// K051962 tile pixel serializer.
package k051962_pkg;

    localparam int unsigned PIX_BITS = 4;
    localparam int unsigned TILE_W   = 8;
    localparam int unsigned COL_W    = 8;
    localparam int unsigned PH_W     = $clog2(TILE_W);
    localparam int unsigned ROW_W    = PIX_BITS * TILE_W;

    typedef struct packed {
        logic [ROW_W-1:0] data;
        logic [COL_W-1:0] col;
        logic             flip;
    } hold_t;

    // Gather pixel idx of a planar row; bit 7 of each plane byte is the leftmost pixel.
    function automatic logic [PIX_BITS-1:0] plane_sel(input logic [ROW_W-1:0] row,
                                                      input logic [PH_W-1:0]  idx,
                                                      input logic             flip);
        logic [PH_W-1:0]     b;
        logic [PIX_BITS-1:0] res;
        b   = flip ? idx : PH_W'(TILE_W - 1) - idx;
        res = '0;
        for (int p = 0; p < PIX_BITS; p++) begin
            res[p] = row[p * TILE_W + int'(b)];
        end
        return res;
    endfunction

endpackage

// File: rtl/k051962_plane_shift.sv
// One bitplane of the pixel shifter: parallel load, then shift towards the
// output end selected by the direction input, filling with zeros.
module k051962_plane_shift
    import k051962_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic              load_i,
    input  logic              dir_i,
    input  logic [TILE_W-1:0] load_data_i,
    output logic [TILE_W-1:0] q_o
);

    logic [TILE_W-1:0] q_q, q_d;

    // dir_i=0 presents bit 7 first (shift left); dir_i=1 presents bit 0 first.
    always_comb begin
        q_d = q_q;
        if (en_i) begin
            if (load_i) begin
                q_d = load_data_i;
            end else if (dir_i) begin
                q_d = q_q >> 1;
            end else begin
                q_d = q_q << 1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/k051962_tile_serializer.sv
// Tile-layer pixel serializer: buffers one GFX ROM row, then shifts it out one
// pixel per PIXCE with fine scroll, X-flip and load/underrun/overrun flags.
module k051962_tile_serializer
    import k051962_pkg::*;
(
    input  logic                m24_i,
    input  logic                res_ni,
    input  logic                pixce_i,
    input  logic                line_clr_i,
    input  logic [PH_W-1:0]     zh_i,
    input  logic                rom_stb_i,
    input  logic [ROW_W-1:0]    rom_d_i,
    input  logic [COL_W-1:0]    col_in_i,
    input  logic                flipx_i,
    output logic [PIX_BITS-1:0] pix_o,
    output logic [COL_W-1:0]    pcol_o,
    output logic                load_o,
    output logic                undr_o,
    output logic                ovr_o
);

    logic [PH_W-1:0]  ph_q, ph_d;
    logic             clr_pend_q, clr_pend_d;
    hold_t            hold_q, hold_d;
    logic             hfull_q, hfull_d;
    logic [COL_W-1:0] pcol_q, pcol_d;
    logic             flip_q, flip_d;
    logic             load_q, undr_q, ovr_q;

    hold_t            rom_in;
    hold_t            load_src;
    logic             load_ev, undr_ev, ovr_ev;
    logic [ROW_W-1:0] shift_row;

    assign rom_in  = {rom_d_i, col_in_i, flipx_i};
    assign load_ev = pixce_i && (ph_q == zh_i);

    always_comb begin
        ph_d       = ph_q;
        clr_pend_d = clr_pend_q;
        if (pixce_i) begin
            ph_d       = (line_clr_i || clr_pend_q) ? '0 : ph_q + PH_W'(1);
            clr_pend_d = 1'b0;
        end else if (line_clr_i) begin
            clr_pend_d = 1'b1;
        end
    end

    // An empty holding register with a coincident strobe feeds ROM data straight through.
    always_comb begin
        load_src = '0;
        if (hfull_q) begin
            load_src = hold_q;
        end else if (rom_stb_i) begin
            load_src = rom_in;
        end
    end

    always_comb begin
        undr_ev = load_ev && !hfull_q && !rom_stb_i;
        ovr_ev  = rom_stb_i && hfull_q && !load_ev;
        hold_d  = hold_q;
        hfull_d = hfull_q;
        if (rom_stb_i && !(load_ev && !hfull_q)) begin
            hold_d  = rom_in;
            hfull_d = 1'b1;
        end else if (load_ev) begin
            hfull_d = 1'b0;
        end
    end

    always_comb begin
        pcol_d = pcol_q;
        flip_d = flip_q;
        if (load_ev) begin
            pcol_d = load_src.col;
            flip_d = load_src.flip;
        end
    end

    always_ff @(posedge m24_i or negedge res_ni) begin
        if (!res_ni) begin
            ph_q       <= '0;
            clr_pend_q <= 1'b0;
            hold_q     <= '0;
            hfull_q    <= 1'b0;
            pcol_q     <= '0;
            flip_q     <= 1'b0;
            load_q     <= 1'b0;
            undr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            ph_q       <= ph_d;
            clr_pend_q <= clr_pend_d;
            hold_q     <= hold_d;
            hfull_q    <= hfull_d;
            pcol_q     <= pcol_d;
            flip_q     <= flip_d;
            load_q     <= load_ev;
            undr_q     <= undr_ev;
            ovr_q      <= ovr_ev;
        end
    end

    for (genvar p = 0; p < PIX_BITS; p++) begin : g_plane
        k051962_plane_shift u_plane (
            .clk_i       (m24_i),
            .rst_ni      (res_ni),
            .en_i        (pixce_i),
            .load_i      (load_ev),
            .dir_i       (flip_q),
            .load_data_i (load_src.data[p*TILE_W +: TILE_W]),
            .q_o         (shift_row[p*TILE_W +: TILE_W])
        );
    end

    // The shifter always holds the current pixel at index 0 of its remaining row.
    assign pix_o  = plane_sel(shift_row, '0, flip_q);
    assign pcol_o = pcol_q;
    assign load_o = load_q;
    assign undr_o = undr_q;
    assign ovr_o  = ovr_q;

endmodule

// File: tb/tb_k051962_tile_serializer.sv
// Self-checking bench for k051962_tile_serializer: cycle scoreboard fed by a
// behavioural row/index model, a vector table and directed corner sequences.
module tb_k051962_tile_serializer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pixce = 1'b0;
    logic        line_clr = 1'b0;
    logic        rom_stb = 1'b0;
    logic        flipx = 1'b0;
    logic [2:0]  zh = 3'd0;
    logic [31:0] rom_d = '0;
    logic [7:0]  col_in = '0;
    logic [3:0]  pix;
    logic [7:0]  pcol;
    logic        load, undr, ovr;

    always #5 clk = ~clk;

    k051962_tile_serializer dut (
        .m24_i      (clk),
        .res_ni     (rst_n),
        .pixce_i    (pixce),
        .line_clr_i (line_clr),
        .zh_i       (zh),
        .rom_stb_i  (rom_stb),
        .rom_d_i    (rom_d),
        .col_in_i   (col_in),
        .flipx_i    (flipx),
        .pix_o      (pix),
        .pcol_o     (pcol),
        .load_o     (load),
        .undr_o     (undr),
        .ovr_o      (ovr)
    );

    typedef struct packed {
        logic [3:0] pix;
        logic [7:0] pcol;
        logic       load;
        logic       undr;
        logic       ovr;
    } obs_t;

    typedef struct {
        logic [2:0]  zh;
        logic [31:0] d;
        logic [7:0]  col;
        logic        fl;
        logic [31:0] ex;
    } vec_t;

    obs_t sb_q[$];
    vec_t tbl[5];
    int   checks = 0;
    int   errors = 0;
    logic last_ld, last_undr, last_ovr;

    // Behavioural model: current row plus a pixel index, no shifting.
    logic [2:0]  m_ph;
    logic        m_pend, m_hfull, m_hflip, m_flip;
    logic [31:0] m_hrow, m_row;
    logic [7:0]  m_hcol, m_col;
    int          m_idx;

    function automatic logic [3:0] ref_pix(input logic [31:0] row, input int i, input logic fl);
        int b;
        b = fl ? i : 7 - i;
        return {row[24+b], row[16+b], row[8+b], row[b]};
    endfunction

    task automatic model_reset();
        m_ph = 3'd0; m_pend = 1'b0; m_hfull = 1'b0;
        m_hrow = '0; m_hcol = '0; m_hflip = 1'b0;
        m_row = '0; m_col = '0; m_flip = 1'b0; m_idx = 8;
    endtask

    task automatic model_step();
        logic le, ue, oe, hf;
        logic [3:0] ep;
        hf = m_hfull;
        le = pixce && (m_ph == zh);
        ue = le && !hf && !rom_stb;
        oe = rom_stb && hf && !le;
        if (pixce) begin
            if (le) begin
                m_idx = 0;
                if (hf) begin
                    m_row = m_hrow; m_col = m_hcol; m_flip = m_hflip;
                end else if (rom_stb) begin
                    m_row = rom_d; m_col = col_in; m_flip = flipx;
                end else begin
                    m_row = '0; m_col = '0; m_flip = 1'b0;
                end
            end else if (m_idx < 8) begin
                m_idx++;
            end
            m_ph   = (line_clr || m_pend) ? 3'd0 : m_ph + 3'd1;
            m_pend = 1'b0;
        end else if (line_clr) begin
            m_pend = 1'b1;
        end
        if (rom_stb && !(le && !hf)) begin
            m_hrow = rom_d; m_hcol = col_in; m_hflip = flipx; m_hfull = 1'b1;
        end else if (le) begin
            m_hfull = 1'b0;
        end
        ep = (m_idx < 8) ? ref_pix(m_row, m_idx, m_flip) : 4'h0;
        sb_q.push_back({ep, m_col, le, ue, oe});
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic ce, input logic stb, input logic lc);
        obs_t e, a;
        pixce = ce; rom_stb = stb; line_clr = lc;
        model_step();
        @(posedge clk);
        #1;
        a = {pix, pcol, load, undr, ovr};
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_empty: got %0h expected queued entry", a);
        end else begin
            e = sb_q.pop_front();
            if (a !== e) begin
                errors++;
                $display("FAIL sb: got pix=%0h pcol=%0h ld=%0b un=%0b ov=%0b expected pix=%0h pcol=%0h ld=%0b un=%0b ov=%0b",
                         a.pix, a.pcol, a.load, a.undr, a.ovr, e.pix, e.pcol, e.load, e.undr, e.ovr);
            end
        end
        last_ld = load; last_undr = undr; last_ovr = ovr;
        pixce = 1'b0; rom_stb = 1'b0; line_clr = 1'b0;
    endtask

    task automatic tick(output logic ld, output logic un);
        cyc(1'b1, 1'b0, 1'b0);
        ld = last_ld; un = last_undr;
        repeat (3) cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_load(input string name, output int n, output logic un);
        logic ld;
        ld = 1'b0; un = 1'b0; n = 0;
        while (!ld && n < 16) begin
            n++;
            tick(ld, un);
        end
        chk(name, 32'(ld), 32'd1);
    endtask

    initial begin
        int          n;
        logic        un, ld;
        logic [31:0] ex;

        tbl[0] = '{3'd0, 32'hFF00_FF00, 8'h5C, 1'b0, 32'hAAAA_AAAA};
        tbl[1] = '{3'd0, 32'h0000_0080, 8'h11, 1'b0, 32'h1000_0000};
        tbl[2] = '{3'd0, 32'h0000_0080, 8'h22, 1'b1, 32'h0000_0001};
        tbl[3] = '{3'd5, 32'h0000_00F0, 8'h44, 1'b0, 32'h1111_0000};
        tbl[4] = '{3'd2, 32'h8040_2010, 8'h99, 1'b1, 32'h0000_1248};

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_pix", 32'(pix), 32'h0);
        chk("reset_flags", {29'd0, load, undr, ovr}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            zh = tbl[i].zh; rom_d = tbl[i].d; col_in = tbl[i].col; flipx = tbl[i].fl;
            cyc(1'b0, 1'b1, 1'b0);
            wait_load("tbl_load", n, un);
            ex = tbl[i].ex;
            chk("tbl_pix0", 32'(pix), 32'(ex[31:28]));
            chk("tbl_pcol", 32'(pcol), 32'(tbl[i].col));
            for (int k = 1; k < 8; k++) begin
                tick(ld, un);
                chk("tbl_pix", 32'(pix), 32'(ex[31-4*k -: 4]));
            end
        end

        // Asynchronous reset while a row is on screen.
        zh = 3'd0; rom_d = 32'hFF00_FF00; col_in = 8'h5C; flipx = 1'b0;
        cyc(1'b0, 1'b1, 1'b0);
        wait_load("rst_pre_load", n, un);
        chk("rst_pre_pix", 32'(pix), 32'hA);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_pix", 32'(pix), 32'h0);
        chk("rst_async_pcol", 32'(pcol), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        wait_load("rst_post_load", n, un);
        chk("rst_post_undr", 32'(un), 32'd1);
        chk("rst_post_pix", 32'(pix), 32'h0);

        // Fine scroll 3 from a line start.
        zh = 3'd3;
        cyc(1'b1, 1'b0, 1'b1);
        repeat (3) cyc(1'b0, 1'b0, 1'b0);
        wait_load("zh3_first", n, un);
        chk("zh3_first_dist", 32'(n), 32'd4);
        wait_load("zh3_next", n, un);
        chk("zh3_period", 32'(n), 32'd8);

        // Overrun: two rows strobed before any load; the newer one wins.
        rom_d = 32'hFF00_FF00; col_in = 8'h5C;
        cyc(1'b0, 1'b1, 1'b0);
        chk("ovr_first", 32'(last_ovr), 32'd0);
        rom_d = 32'h8040_2010; col_in = 8'h77; flipx = 1'b0;
        cyc(1'b0, 1'b1, 1'b0);
        chk("ovr_second", 32'(last_ovr), 32'd1);
        wait_load("ovr_load", n, un);
        chk("ovr_pix", 32'(pix), 32'h8);
        chk("ovr_pcol", 32'(pcol), 32'h77);

        // Strobe coincident with a load while the holding register is full.
        rom_d = 32'hFF00_FF00; col_in = 8'h5C;
        cyc(1'b0, 1'b1, 1'b0);
        n = 0;
        while (m_ph != zh && n < 8) begin
            n++;
            tick(ld, un);
        end
        rom_d = 32'h8040_2010; col_in = 8'h33;
        cyc(1'b1, 1'b1, 1'b0);
        chk("coin_load", 32'(last_ld), 32'd1);
        chk("coin_ovr_undr", {30'd0, last_ovr, last_undr}, 32'd0);
        chk("coin_pix", 32'(pix), 32'hA);
        chk("coin_pcol", 32'(pcol), 32'h5C);
        repeat (3) cyc(1'b0, 1'b0, 1'b0);
        wait_load("coin_next", n, un);
        chk("coin_next_undr", 32'(un), 32'd0);
        chk("coin_next_pix", 32'(pix), 32'h8);
        chk("coin_next_pcol", 32'(pcol), 32'h33);

        // Random traffic, scoreboard only.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(63) == 0) zh = 3'($urandom_range(7));
            rom_d = $urandom(); col_in = 8'($urandom()); flipx = 1'($urandom());
            cyc(1'((c % 4) == 0), 1'($urandom_range(9) == 0), 1'($urandom_range(40) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
